// File: rtl/bitsel_pkg.sv
// Shared types and index helpers for the bit-select serializer and its
// downstream checker. All index math is done in 32-bit signed int so that
// declared bounds and select indices never truncate against each other.
package bitsel_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Number of bits in a word declared [msb:lsb], either direction.
    function automatic int width_of(input int msb, input int lsb);
        return (msb >= lsb) ? (msb - lsb + 1) : (lsb - msb + 1);
    endfunction

    // True when idx names a bit of a word declared [msb:lsb].
    function automatic logic in_range(input int idx, input int msb, input int lsb);
        if (msb >= lsb) begin
            return (idx >= lsb) && (idx <= msb);
        end
        return (idx >= msb) && (idx <= lsb);
    endfunction

    // Distance of idx from the right end of the word; only meaningful in range.
    function automatic int bit_offset(input int idx, input int msb, input int lsb);
        return (msb >= lsb) ? (idx - lsb) : (lsb - idx);
    endfunction

endpackage

// File: rtl/bitsel_pick.sv
// Combinational bit picker: returns data[idx] for a word declared [MSB:LSB]
// together with an out-of-range flag.
// Build option: BITSEL_SER_OOB_X_EN drives 1'bx on out-of-range picks
// (simulation select semantics); otherwise out-of-range picks return 0.
module bitsel_pick
    import bitsel_pkg::*;
#(
    parameter int          MSB   = 4,
    parameter int          LSB   = 0,
    parameter int unsigned IDX_W = 5
) (
    input  logic                    [MSB:LSB] data_i,
    input  logic signed [IDX_W-1:0]           idx_i,
    output logic                              bit_o,
    output logic                              oob_o
);

    localparam int unsigned DATA_W = $unsigned(width_of(MSB, LSB));

    logic [DATA_W-1:0] flat;
    logic              sel;
    int                off;

    // Flatten the word so the right-hand declared bit sits at flat[0].
    assign flat = data_i;

    // Range check and one-hot mask select; a negative or oversized offset
    // shifts the mask out entirely, and the oob flag masks the result anyway.
    always_comb begin
        off   = bit_offset(int'(idx_i), MSB, LSB);
        oob_o = !in_range(int'(idx_i), MSB, LSB);
        sel   = |(flat & (DATA_W'(1) << off));
`ifdef BITSEL_SER_OOB_X_EN
        bit_o = oob_o ? 1'bx : sel;
`else
        bit_o = oob_o ? 1'b0 : sel;
`endif
    end

endmodule

// File: rtl/bitsel_serializer.sv
// Serializes a packed word declared [MSB:LSB] into single-bit beats by
// walking a signed, wrapping select index from in_start for in_count beats.
// Each beat reports the index used and whether it fell outside the range.
// Build option: BITSEL_SER_OOB_X_EN (see bitsel_pick) makes out-of-range
// beats carry 1'bx instead of 0.
module bitsel_serializer
    import bitsel_pkg::*;
#(
    parameter int          MSB   = 4,
    parameter int          LSB   = 0,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [MSB:LSB]   in_data,
    input  logic signed [IDX_W-1:0] in_start,
    input  logic        [CNT_W-1:0] in_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic signed [IDX_W-1:0] out_idx,
    output logic                    out_oob,
    output logic                    out_last
);

    state_e                  state_q, state_d;
    logic        [MSB:LSB]   data_q, data_d;
    logic signed [IDX_W-1:0] idx_q, idx_d;
    logic        [CNT_W-1:0] rem_q, rem_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic                    pick_bit;
    logic                    pick_oob;

    // State and command registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: accept in IDLE, step index/remaining count per beat in EMIT.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid && (in_count != '0)) begin
                    data_d  = in_data;
                    idx_d   = in_start;
                    rem_d   = in_count;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    // Bit lookup on the held word at the current index.
    bitsel_pick #(
        .MSB   (MSB),
        .LSB   (LSB),
        .IDX_W (IDX_W)
    ) u_pick (
        .data_i (data_q),
        .idx_i  (idx_q),
        .bit_o  (pick_bit),
        .oob_o  (pick_oob)
    );

    // Beat payload decoded from registered state, forced quiet when idle.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign out_bit   = out_valid_q & pick_bit;
    assign out_oob   = out_valid_q & pick_oob;
    assign out_last  = out_valid_q & (rem_q == CNT_W'(1));

endmodule

// File: tb/tb_bitsel_serializer.sv
// Scoreboard bench for bitsel_serializer: three instances with different
// declared ranges (little-endian with negative LSB, big-endian, all-negative),
// driven one at a time by a shared stimulus process.
module tb_bitsel_serializer;

    typedef struct {
        int   idx;
        logic bitv;
        logic bit_care;
        logic oob;
        logic last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              iv;
    logic        [6:0] din;
    logic signed [4:0] st;
    logic        [5:0] cnt;
    logic              ordy;
    logic              man_rdy;
    logic              rnd_bit = 1'b1;
    logic              rand_mode;
    int                cur;
    logic              started = 1'b0;

    logic [2:0]        ir, ov, ob, oo, ol;
    logic [2:0][4:0]   oi;

    beat_t             exp_q[$];
    int                total = 0;
    int                bad   = 0;

    logic              hold_pend = 1'b0;
    logic              held_bit, held_oob, held_last;
    logic [4:0]        held_idx;

    always #5 clk = ~clk;

    assign ordy = rand_mode ? rnd_bit : man_rdy;

    function automatic int msb_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 0 : -2;
    endfunction

    function automatic int lsb_of(input int g);
        return (g == 0) ? -2 : (g == 1) ? 6 : -7;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int M = (g == 0) ? 4 : (g == 1) ? 0 : -2;
        localparam int L = (g == 0) ? -2 : (g == 1) ? 6 : -7;
        localparam int W = (M >= L) ? (M - L + 1) : (L - M + 1);
        bitsel_serializer #(.MSB(M), .LSB(L), .IDX_W(5), .CNT_W(6)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv && (cur == g)),
            .in_ready  (ir[g]),
            .in_data   (din[W-1:0]),
            .in_start  (st),
            .in_count  (cnt),
            .out_valid (ov[g]),
            .out_ready (ordy),
            .out_bit   (ob[g]),
            .out_idx   (oi[g]),
            .out_oob   (oo[g]),
            .out_last  (ol[g])
        );
    end

    // Random downstream readiness, used only in the random phase.
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Reference model: map every declared index to its position from the
    // right end of the word, then walk a 5-bit wrapping index.
    task automatic push_expected(input int g, input logic [6:0] d, input int start, input int count);
        int    m, l, dir, w, idx, v;
        int    pos_of[int];
        beat_t e;
        m   = msb_of(g);
        l   = lsb_of(g);
        dir = (m >= l) ? 1 : -1;
        w   = (m - l) * dir + 1;
        for (int p = 0; p < w; p++) pos_of[l + p * dir] = p;
        for (int k = 0; k < count; k++) begin
            v   = start + k + 16;
            idx = ((v % 32) + 32) % 32 - 16;
            e.idx  = idx;
            e.last = (k == count - 1);
            if (pos_of.exists(idx)) begin
                e.oob      = 1'b0;
                e.bitv     = d[pos_of[idx]];
                e.bit_care = 1'b1;
            end else begin
                e.oob  = 1'b1;
                e.bitv = 1'b0;
`ifdef BITSEL_SER_OOB_X_EN
                e.bit_care = 1'b0;
`else
                e.bit_care = 1'b1;
`endif
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks that
    // a stalled beat keeps its payload and that no command is accepted.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else if (started) begin
            for (int g = 0; g < 3; g++) begin
                if (g != cur) begin
                    total++;
                    if (ov[g] !== 1'b0) begin
                        bad++;
                        $display("FAIL idle_instance g=%0d out_valid=%b want 0", g, ov[g]);
                    end
                end
            end
            if (ov[cur] === 1'b1) begin
                total++;
                if (ir[cur] !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_in_ready g=%0d in_ready=%b want 0", cur, ir[cur]);
                end
                if (hold_pend) begin
                    total++;
                    if (ob[cur] !== held_bit || oi[cur] !== held_idx ||
                        oo[cur] !== held_oob || ol[cur] !== held_last) begin
                        bad++;
                        $display("FAIL stall_stable g=%0d got bit=%b idx=%0d oob=%b last=%b want bit=%b idx=%0d oob=%b last=%b",
                                 cur, ob[cur], $signed(oi[cur]), oo[cur], ol[cur],
                                 held_bit, $signed(held_idx), held_oob, held_last);
                    end
                end
                if (ordy) begin
                    hold_pend = 1'b0;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat g=%0d idx=%0d got a beat, want none", cur, $signed(oi[cur]));
                    end else begin
                        e = exp_q.pop_front();
                        if (int'($signed(oi[cur])) != e.idx || oo[cur] !== e.oob ||
                            ol[cur] !== e.last || (e.bit_care && ob[cur] !== e.bitv)) begin
                            bad++;
                            $display("FAIL beat g=%0d got idx=%0d bit=%b oob=%b last=%b want idx=%0d bit=%b oob=%b last=%b",
                                     cur, $signed(oi[cur]), ob[cur], oo[cur], ol[cur],
                                     e.idx, e.bitv, e.oob, e.last);
                        end
                    end
                end else begin
                    hold_pend = 1'b1;
                    held_bit  = ob[cur];
                    held_idx  = oi[cur];
                    held_oob  = oo[cur];
                    held_last = ol[cur];
                end
            end else begin
                if (hold_pend) begin
                    total++;
                    bad++;
                    $display("FAIL stall_dropped g=%0d out_valid=0 want 1", cur);
                end
                hold_pend = 1'b0;
            end
        end
    end

    task automatic check_reset_vals(input int g);
        total++;
        if (ir[g] !== 1'b1 || ov[g] !== 1'b0 || ob[g] !== 1'b0 || oi[g] !== 5'd0 ||
            oo[g] !== 1'b0 || ol[g] !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals g=%0d got rdy=%b vld=%b bit=%b idx=%0d oob=%b last=%b want 1 0 0 0 0 0",
                     g, ir[g], ov[g], ob[g], $signed(oi[g]), oo[g], ol[g]);
        end
    endtask

    // Issue one command; called just after a rising edge.
    task automatic send(input int g, input logic [6:0] d, input int start, input int count);
        cur = g;
        total++;
        if (ir[g] !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_idle g=%0d in_ready=%b want 1", g, ir[g]);
        end
        din = d;
        st  = 5'(start);
        cnt = 6'(count);
        iv  = 1'b1;
        push_expected(g, d, start, count);
        @(posedge clk);
        #1;
        iv = 1'b0;
        total++;
        if (ov[g] !== (count > 0)) begin
            bad++;
            $display("FAIL first_beat g=%0d out_valid=%b want %b", g, ov[g], count > 0);
        end
        if (count == 0) begin
            total++;
            if (ir[g] !== 1'b1) begin
                bad++;
                $display("FAIL zero_count_ready g=%0d in_ready=%b want 1", g, ir[g]);
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout g=%0d left=%0d want 0", cur, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        iv        = 1'b0;
        din       = '0;
        st        = '0;
        cnt       = '0;
        man_rdy   = 1'b1;
        rand_mode = 1'b0;
        cur       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) check_reset_vals(g);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;

        // Little-endian with negative LSB, full sweep.
        send(0, 7'b1011001, -2, 7);
        wait_drain(50);

        // Big-endian, starting one below the range.
        send(1, 7'b1000000, -1, 3);
        wait_drain(50);

        // All-negative range, index wraps 15 -> -16.
        send(2, 7'($urandom), 14, 4);
        wait_drain(50);

        // Backpressure: beat 2 stalled for three cycles.
        send(0, 7'($urandom), 0, 5);
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        man_rdy = 1'b1;
        wait_drain(50);

        // Zero-count command, then a normal one right behind it.
        send(1, 7'($urandom), 3, 0);
        send(1, 7'b0101010, 2, 2);
        wait_drain(50);

        // Reset while beat 3 of 6 is presented.
        send(1, 7'($urandom), 0, 6);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals(1);
        exp_q.delete();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_reset_vals(1);

        // Random commands with random downstream readiness.
        rand_mode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            send(int'($urandom_range(0, 2)), 7'($urandom),
                 int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 20)));
            wait_drain(400);
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
